// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback request side, the CLEAR control/status and the
// register file write port of regfile_wb_arbiter.
//   req_valid  [NUM_REQ]             per-requester write request
//   req_addr   [NUM_REQ*ADDR_WIDTH]  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   [NUM_REQ*DATA_WIDTH]  same packing as req_addr
//   req_ready  [NUM_REQ]             one-hot (or zero) accept
//   clear                            start a register clear sweep
//   clear_busy / clear_done          sweep status / last-write pulse
//   drop                             accepted request targeted address 0
//   we / waddr / wdata               register file write port
// modport master: requester/control side; modport slave: the arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          clear;
    logic                          clear_busy;
    logic                          clear_done;
    logic                          drop;
    logic                          we;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [DATA_WIDTH-1:0]         wdata;

    modport master (
        output req_valid, req_addr, req_data, clear,
        input  req_ready, clear_busy, clear_done, drop, we, waddr, wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, clear,
        output req_ready, clear_busy, clear_done, drop, we, waddr, wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file write port between NUM_REQ writeback requesters
// using round-robin arbitration with valid/ready handshakes, and provides an
// on-demand CLEAR sweep that zeroes registers 1..REG_COUNT-1.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     regfile_wb_arbiter_if.slave (requests, clear control, write port)
// Build option:
//   WB_OUTPUT_REG_EN  when defined, we/waddr/wdata/drop/clear_done are
//                     registered (write lands one cycle after the handshake);
//                     req_ready stays combinational. Undefined: fully
//                     combinational write path.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {ST_ARB, ST_CLEAR} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic                    found;
    logic [PTR_W-1:0]        win;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_REQ-1:0]      ready_c;
    logic                    we_c, drop_c, done_c;
    logic [ADDR_WIDTH-1:0]   waddr_c;
    logic [DATA_WIDTH-1:0]   wdata_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ARB;
            rr_q    <= '0;
            cnt_q   <= ADDR_WIDTH'(1);
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        ready_c  = '0;
        we_c     = 1'b0;
        drop_c   = 1'b0;
        done_c   = 1'b0;
        waddr_c  = '0;
        wdata_c  = '0;
        found    = 1'b0;
        win      = '0;
        sel_addr = '0;
        sel_data = '0;

        // Round-robin search as two passes: indices at or above rr_q first,
        // then the wrapped-around indices below it.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (PTR_W'(i) >= rr_q)) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (PTR_W'(i) < rr_q)) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win) begin
                sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Outputs are forced quiet while reset is asserted, so an abort
        // mid-sweep silences the write port immediately.
        if (rst_ni) begin
            unique case (state_q)
                ST_ARB: begin
                    if (bus.clear) begin
                        state_d = ST_CLEAR;
                    end else if (found) begin
                        ready_c[win] = 1'b1;
                        rr_d = (win == LAST_PTR) ? '0 : win + 1'b1;
                        if (sel_addr != '0) begin
                            we_c    = 1'b1;
                            waddr_c = sel_addr;
                            wdata_c = sel_data;
                        end else begin
                            drop_c = 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    we_c    = 1'b1;
                    waddr_c = cnt_q;
                    if (cnt_q == LAST_ADDR) begin
                        done_c  = 1'b1;
                        cnt_d   = ADDR_WIDTH'(1);
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    assign bus.req_ready = ready_c;

`ifdef WB_OUTPUT_REG_EN
    logic                  we_q, drop_q, done_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_c;
            drop_q  <= drop_c;
            done_q  <= done_c;
            waddr_q <= waddr_c;
            wdata_q <= wdata_c;
        end
    end

    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.drop       = drop_q;
    assign bus.clear_done = done_q;
    // Busy stretches over the registered copy of the last sweep write.
    assign bus.clear_busy = (state_q == ST_CLEAR) || done_q;
`else
    assign bus.we         = we_c;
    assign bus.waddr      = waddr_c;
    assign bus.wdata      = wdata_c;
    assign bus.drop       = drop_c;
    assign bus.clear_done = done_c;
    assign bus.clear_busy = (state_q == ST_CLEAR);
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int REG_COUNT = 32;
    localparam int VW        = NUM_REQ + 1 + AW + DW + 3;
`ifdef WB_OUTPUT_REG_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .REG_COUNT(REG_COUNT)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Requester side
    logic          p_valid [NUM_REQ];
    logic [AW-1:0] p_addr  [NUM_REQ];
    logic [DW-1:0] p_data  [NUM_REQ];
    logic          clr_in;

    // Reference model: rr pointer and the next clear address (0 = arbitrating)
    int m_rr  = 0;
    int m_clr = 0;

    // This cycle's behaviour, and the previous cycle's write (registered build)
    int                 c_win;
    logic [NUM_REQ-1:0] c_ready;
    logic               c_we, c_drop, c_done;
    logic [AW-1:0]      c_waddr;
    logic [DW-1:0]      c_wdata;
    logic               d_we = 1'b0, d_drop = 1'b0, d_done = 1'b0;
    logic [AW-1:0]      d_waddr = '0;
    logic [DW-1:0]      d_wdata = '0;
    logic [VW-1:0]      expv;

    function automatic logic [VW-1:0] obs();
        return {bus.req_ready, bus.we, bus.waddr, bus.wdata, bus.drop,
                bus.clear_busy, bus.clear_done};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]            = p_valid[i];
            bus.req_addr[i*AW +: AW]    = p_addr[i];
            bus.req_data[i*DW +: DW]    = p_data[i];
        end
        bus.clear = clr_in;
    endtask

    task automatic model_eval();
        int i;
        c_win = -1; c_ready = '0; c_we = 1'b0; c_drop = 1'b0; c_done = 1'b0;
        c_waddr = '0; c_wdata = '0;
        if (m_clr != 0) begin
            c_we    = 1'b1;
            c_waddr = AW'(m_clr);
            c_done  = (m_clr == REG_COUNT - 1);
        end else if (!clr_in) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_rr + k) % NUM_REQ;
                if (c_win < 0 && p_valid[i]) c_win = i;
            end
            if (c_win >= 0) begin
                c_ready[c_win] = 1'b1;
                if (p_addr[c_win] != 0) begin
                    c_we = 1'b1; c_waddr = p_addr[c_win]; c_wdata = p_data[c_win];
                end else begin
                    c_drop = 1'b1;
                end
            end
        end
`ifdef WB_OUTPUT_REG_EN
        expv = {c_ready, d_we, d_waddr, d_wdata, d_drop, (m_clr != 0) || d_done, d_done};
`else
        expv = {c_ready, c_we, c_waddr, c_wdata, c_drop, m_clr != 0, c_done};
`endif
    endtask

    task automatic model_reset();
        m_rr = 0; m_clr = 0;
        d_we = 1'b0; d_drop = 1'b0; d_done = 1'b0; d_waddr = '0; d_wdata = '0;
    endtask

    task automatic settle();
        drive();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk_i);
        d_we = c_we; d_drop = c_drop; d_done = c_done; d_waddr = c_waddr; d_wdata = c_wdata;
        if (m_clr != 0)      m_clr = (m_clr == REG_COUNT - 1) ? 0 : m_clr + 1;
        else if (clr_in)     m_clr = 1;
        else if (c_win >= 0) begin
            m_rr = (c_win + 1) % NUM_REQ;
            p_valid[c_win] = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            p_valid[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        clr_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got;
        idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            p_valid[i] = 1'b1; p_addr[i] = AW'(i + 3); p_data[i] = $urandom;
        end
        rst_ni = 1'b0;
        drive();
        @(negedge clk_i); @(negedge clk_i);
        #1;
        got = obs();
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", got);
        end
        idle_inputs();
        drive();
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv || got !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", c, got, expv);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [VW-1:0]      got;
        logic [NUM_REQ-1:0] want_r;
        logic [AW-1:0]      want_a;
        for (int c = 0; c < 4 + DLY; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                p_valid[i] = 1'b1;
                p_addr[i]  = AW'(5 + i);
                p_data[i]  = 32'hA0A0_0000 + 32'(i);
            end
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL rr_model cyc %0d: got %h want %h", c, got, expv);
            end
            want_r = NUM_REQ'(1 << (c % 3));
            n_cmp++;
            if (bus.req_ready !== want_r) begin
                n_fail++;
                $display("FAIL rr_grant cyc %0d: got %b want %b", c, bus.req_ready, want_r);
            end
            if (c >= DLY) begin
                want_a = AW'(5 + (c - DLY) % 3);
                n_cmp++;
                if (bus.we !== 1'b1 || bus.waddr !== want_a) begin
                    n_fail++;
                    $display("FAIL rr_waddr cyc %0d: got we=%b a=%0d want we=1 a=%0d",
                             c, bus.we, bus.waddr, want_a);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_addr_zero();
        logic [VW-1:0] got;
        idle_inputs();
        p_valid[1] = 1'b1; p_addr[1] = '0; p_data[1] = $urandom;
        for (int c = 0; c < 3; c++) begin
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL zero_model cyc %0d: got %h want %h", c, got, expv);
            end
            if (c == 0) begin
                n_cmp++;
                if (bus.req_ready !== 3'b010) begin
                    n_fail++;
                    $display("FAIL zero_ready: got %b want 010", bus.req_ready);
                end
            end
            n_cmp++;
            if (bus.drop !== (c == DLY) || bus.we !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_drop cyc %0d: got drop=%b we=%b want drop=%b we=0",
                         c, bus.drop, bus.we, c == DLY);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        logic [VW-1:0] got;
        int writes, dones, grant_cyc;
        idle_inputs();
        p_valid[0] = 1'b1; p_addr[0] = 5'd9; p_data[0] = 32'h1234_5678;
        clr_in = 1'b1;
        settle();
        got = obs();
        n_cmp++;
        if (got !== expv || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL clear_start: got %h want %h", got, expv);
        end
        tick();
        writes = 0; dones = 0; grant_cyc = -1;
        for (int j = 0; j < REG_COUNT + 4; j++) begin
            clr_in = (j < REG_COUNT - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL clear_model cyc %0d: got %h want %h", j, got, expv);
            end
            if (bus.we === 1'b1 && bus.wdata === '0 && bus.waddr !== '0) writes++;
            if (bus.clear_done === 1'b1) dones++;
            if (bus.req_ready[0] === 1'b1 && grant_cyc < 0) grant_cyc = j;
            tick();
        end
        n_cmp++;
        if (writes != REG_COUNT - 1 || dones != 1 || grant_cyc != REG_COUNT - 1) begin
            n_fail++;
            $display("FAIL clear_sweep: got writes=%0d dones=%0d grant=%0d want %0d/1/%0d",
                     writes, dones, grant_cyc, REG_COUNT - 1, REG_COUNT - 1);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        logic [VW-1:0] got;
        bit hit;
        idle_inputs();
        clr_in = 1'b1;
        settle();
        tick();
        clr_in = 1'b0;
        hit = 0;
        for (int j = 0; j < 40 && !hit; j++) begin
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL abort_model cyc %0d: got %h want %h", j, got, expv);
            end
            if (bus.we === 1'b1 && bus.waddr === 5'd10) hit = 1;
            else tick();
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_reach: got no write to 10 want one within 40 cycles");
        end
        rst_ni = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h want 0", got);
        end
        model_reset();
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv || bus.we !== 1'b0 || bus.clear_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_after cyc %0d: got %h want %h", c, got, expv);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
                    p_valid[i] = 1'b1;
                    p_addr[i]  = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
                    p_data[i]  = $urandom;
                end
            end
            clr_in = ($urandom_range(0, 99) == 0);
            settle();
            got = obs();
            n_cmp++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", c, got, expv);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        drive();
        @(negedge clk_i);
        test_reset();
        test_round_robin();
        test_addr_zero();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
